irq_priority_ctrl: RTL and testbench

Parametrised multi-source interrupt controller for the single-cycle RISC-V core, replacing the single-line controller.
- Accepts `N_IRQ` request lines, each configured as edge- or level-sensitive, with per-line mask and global enable.
- Selects the highest-priority pending line and raises a trap request with a distinct `mcause` per line.
- Tracks one level of exception nesting inside an interrupt handler.
- Returns a per-line one-hot acknowledge on `mret`.

Sits between external peripherals and the core's trap/CSR logic.

---
 rtl/irq_priority_ctrl_pkg.sv | 20 ++
 rtl/irq_priority_ctrl_prio_enc.sv | 23 ++
 rtl/irq_priority_ctrl.sv | 113 +++++++++++
 tb/tb_irq_priority_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_priority_ctrl_pkg.sv
// Shared types and constants for the multi-line interrupt controller.
// Holds the handler state encoding and the mcause base for external interrupts.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IRQ     = 2'd1,
    EXC     = 2'd2,
    IRQ_EXC = 2'd3
  } irq_state_t;

  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
  localparam int          IRQ_MAX        = 16;

  // Line id is at most 4 bits wide, so a 5-bit zero-extended add never carries out.
  function automatic logic [31:0] irq_cause(input logic [4:0] id);
    return IRQ_CAUSE_BASE + {27'd0, id};
  endfunction

endpackage

// File: rtl/irq_priority_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational, zero latency.
// Bit 0 has the highest priority; o_any flags a non-empty input vector.
module irq_prio_enc #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_id,
  output logic         o_any
);

  always_comb begin
    o_id  = '0;
    o_any = |i_vec;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_id = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Multi-line interrupt controller: pending capture, priority select, one-level nesting.
// Take fires the cycle after a request registers; stall_i freezes the handler state.
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int               N_IRQ     = 16,
  parameter logic [N_IRQ-1:0] EDGE_MASK = {N_IRQ{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             mie_i,
  input  logic             exception_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic [N_IRQ-1:0] irq_pending_o
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t       r_st;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_req_q;
  logic [ID_W-1:0]  r_cur_id;

  logic [N_IRQ-1:0] w_cand;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_take_clr;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic [ID_W-1:0]  w_sel_id;
  logic [4:0]       w_cause_id;
  logic             w_any;
  logic             w_run;
  logic             w_take;

  assign w_run  = ~stall_i;
  assign w_cand = r_pend & irq_mask_i;

  irq_prio_enc #(
    .N (N_IRQ),
    .W (ID_W)
  ) u_prio_enc (
    .i_vec (w_cand),
    .o_id  (w_sel_id),
    .o_any (w_any)
  );

  assign w_take = (r_st == IDLE) & mie_i & w_any & ~exception_i & ~mret_i & w_run;
  assign w_rise = irq_req_i & ~r_req_q;

  // Only edge lines are consumed by a take; a rise in the same cycle re-arms the line.
  assign w_take_clr = w_take ? ((N_IRQ'(1) << w_sel_id) & EDGE_MASK) : '0;
  assign w_pend_nxt = (EDGE_MASK & ((r_pend & ~w_take_clr) | w_rise))
                    | (~EDGE_MASK & irq_req_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend  <= '0;
      r_req_q <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_req_q <= irq_req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_st     <= IDLE;
      r_cur_id <= '0;
    end else if (w_run) begin
      case (r_st)
        IDLE: begin
          if (exception_i) begin
            r_st <= EXC;
          end else if (w_take) begin
            r_st     <= IRQ;
            r_cur_id <= w_sel_id;
          end
        end
        // mret wins over a coincident exception so the state matches the ack pulse.
        IRQ: begin
          if (mret_i) begin
            r_st <= IDLE;
          end else if (exception_i) begin
            r_st <= IRQ_EXC;
          end
        end
        EXC: begin
          if (mret_i) begin
            r_st <= IDLE;
          end
        end
        IRQ_EXC: begin
          if (mret_i) begin
            r_st <= IRQ;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  assign w_cause_id    = 5'((r_st == IDLE) ? w_sel_id : r_cur_id);
  assign irq_o         = w_take;
  assign irq_cause_o   = irq_cause(w_cause_id);
  assign irq_ret_o     = ((r_st == IRQ) && mret_i && w_run) ? (N_IRQ'(1) << r_cur_id) : '0;
  assign irq_pending_o = r_pend;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scenario bench for irq_priority_ctrl: per-cycle expectations queued at drive time.
module tb_irq_priority_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [15:0] irq_req_i;
  logic [15:0] irq_mask_i;
  logic        mie_i;
  logic        exception_i;
  logic        mret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic [15:0] irq_pending_o;

  // Line 1 is level sensitive, all others edge sensitive.
  irq_priority_ctrl #(
    .N_IRQ     (16),
    .EDGE_MASK (16'hFFFD)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .irq_req_i     (irq_req_i),
    .irq_mask_i    (irq_mask_i),
    .mie_i         (mie_i),
    .exception_i   (exception_i),
    .mret_i        (mret_i),
    .irq_o         (irq_o),
    .irq_cause_o   (irq_cause_o),
    .irq_ret_o     (irq_ret_o),
    .irq_pending_o (irq_pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic        mie;
    logic        exc;
    logic        mret;
    logic        stall;
    logic        irq;
    logic [31:0] cause;
    logic [15:0] ret;
    logic [15:0] pend;
  } step_t;

  typedef struct {
    logic        irq;
    logic [31:0] cause;
    logic [15:0] ret;
    logic [15:0] pend;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic step_t mk(logic [15:0] req, logic exc, logic mret, logic stall,
                               logic irq, int cid, logic [15:0] ret, logic [15:0] pend,
                               logic rst = 1'b0, logic [15:0] mask = 16'hFFFF, logic mie = 1'b1);
    step_t s;
    s.rst = rst; s.req = req; s.mask = mask; s.mie = mie;
    s.exc = exc; s.mret = mret; s.stall = stall;
    s.irq = irq; s.cause = 32'h8000_0010 + cid; s.ret = ret; s.pend = pend;
    return s;
  endfunction

  task automatic drive_step(input step_t s);
    exp_t e;
    rst_i = s.rst; irq_req_i = s.req; irq_mask_i = s.mask; mie_i = s.mie;
    exception_i = s.exc; mret_i = s.mret; stall_i = s.stall;
    e.irq = s.irq; e.cause = s.cause; e.ret = s.ret; e.pend = s.pend;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t tbl[$];
    exp_t  e;
    rst_i = 1'b1; irq_req_i = '0; irq_mask_i = 16'hFFFF; mie_i = 1'b1;
    exception_i = 1'b0; mret_i = 1'b0; stall_i = 1'b0;
    @(negedge clk_i);
    tbl.push_back(mk(16'h0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1'b1));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(16'h0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL reset step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  task automatic test_edge_priority();
    step_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(16'h0024, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 2, 16'h0000, 16'h0024));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 2, 16'h0000, 16'h0020));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 2, 16'h0004, 16'h0020));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 5, 16'h0000, 16'h0020));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 5, 16'h0020, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL edge_priority step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  task automatic test_exception_blocks();
    step_t tbl[$];
    exp_t  e;
    // cur_id still holds line 5 from the previous handler while in EXC.
    tbl.push_back(mk(16'h0008, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0008, 1, 0, 0, 0, 3, 16'h0000, 16'h0008));
    tbl.push_back(mk(16'h0008, 0, 0, 0, 0, 5, 16'h0000, 16'h0008));
    tbl.push_back(mk(16'h0008, 0, 1, 0, 0, 5, 16'h0000, 16'h0008));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 3, 16'h0000, 16'h0008));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 3, 16'h0008, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL exception_blocks step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  task automatic test_nesting();
    step_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(16'h0080, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 7, 16'h0000, 16'h0080));
    tbl.push_back(mk(16'h0000, 1, 0, 0, 0, 7, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 1, 0, 0, 0, 7, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 7, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 7, 16'h0080, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL nesting step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  task automatic test_stall_level();
    step_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(16'h0002, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(16'h0002, 0, 0, 1, 0, 1, 16'h0000, 16'h0002));
    tbl.push_back(mk(16'h0002, 0, 0, 0, 1, 1, 16'h0000, 16'h0002));
    tbl.push_back(mk(16'h0002, 0, 1, 0, 0, 1, 16'h0002, 16'h0002));
    tbl.push_back(mk(16'h0002, 0, 0, 0, 1, 1, 16'h0000, 16'h0002));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 1, 16'h0002, 16'h0002));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL stall_level step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  task automatic test_mask_enable();
    step_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(16'h0001, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1'b0, 16'hFFFE));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 1'b0, 16'hFFFE));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 1'b0, 16'hFFFE));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 0, 16'h0000, 16'h0001));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 16'h0001, 16'h0000));
    tbl.push_back(mk(16'h0200, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 9, 16'h0000, 16'h0200, 1'b0, 16'hFFFF, 1'b0));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 9, 16'h0000, 16'h0200));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 9, 16'h0200, 16'h0000));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL mask_enable step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  task automatic test_reset_mid_handler();
    step_t tbl[$];
    exp_t  e;
    // After reset req_q is zero, so a still-high edge line registers a fresh rise.
    tbl.push_back(mk(16'h0040, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0010, 0, 0, 0, 1, 6, 16'h0000, 16'h0040));
    tbl.push_back(mk(16'h0010, 0, 0, 0, 0, 6, 16'h0000, 16'h0010, 1'b1));
    tbl.push_back(mk(16'h0010, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 4, 16'h0000, 16'h0010));
    tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 4, 16'h0000, 16'h0010));
    tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 4, 16'h0010, 16'h0000));
    foreach (tbl[i]) begin
      @(negedge clk_i); drive_step(tbl[i]); #2;
      e = sb.pop_front(); n_tests++;
      if ({irq_o, irq_cause_o, irq_ret_o, irq_pending_o} !== {e.irq, e.cause, e.ret, e.pend}) begin
        n_fail++;
        $display("FAIL reset_mid_handler step %0d: got irq=%b cause=%h ret=%h pend=%h, expected irq=%b cause=%h ret=%h pend=%h",
                 i, irq_o, irq_cause_o, irq_ret_o, irq_pending_o, e.irq, e.cause, e.ret, e.pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_priority();
    test_exception_blocks();
    test_nesting();
    test_stall_level();
    test_mask_enable();
    test_reset_mid_handler();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

endmodule
